// File: rtl/product_bcd_converter.sv
// -----------------------------------------------------------------------------
// product_bcd_converter
//
// Converts the signed 16-bit product of the shift-add multiplier ({A, B}) into
// a sign flag plus DIGITS packed BCD digits. The conversion runs one
// shift-and-add-3 (double-dabble) step per clock on the magnitude of the
// captured product.
//
// State table:
//   state | meaning
//   IDLE  | waiting for Start; Product is captured on the accepting edge
//   CONV  | one double-dabble iteration per edge, WIDTH edges in total
//   DONE  | Done pulse for one cycle; always returns to IDLE on the next edge
//
// Ports:
//   Clk      in   system clock, rising edge active
//   Reset    in   synchronous active-high reset
//   Start    in   conversion request, only looked at in IDLE
//   Product  in   WIDTH-bit two's-complement value to convert
//   Busy     out  high while iterations are in progress
//   Done     out  one-cycle pulse when Digits/Neg carry a new result
//   Neg      out  sign of the converted value (1 = negative)
//   Digits   out  packed BCD result, [3:0] is the ones digit
// -----------------------------------------------------------------------------
module product_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [WIDTH-1:0]      Product,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Neg,
    output logic [4*DIGITS-1:0]   Digits
);

    localparam int              CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [WIDTH-1:0]    mag;
    logic [4*DIGITS-1:0] bcd;
    logic [CW-1:0]       iter;
    logic                neg_reg;

    logic [WIDTH-1:0]    mag_abs;
    logic [4*DIGITS-1:0] bcd_shift;
    logic [3:0]          dig;
    logic                carry;
    logic                last_iter;

    // Magnitude is kept unsigned, so the most negative input (0x8000) maps
    // to 32768 without overflow.
    always_comb begin
        mag_abs = Product;
        if (Product[WIDTH-1]) begin
            mag_abs = ~Product + WIDTH'(1);
        end
    end

    // One double-dabble step: correct every digit that is >= 5 on its
    // pre-shift value, then shift {bcd, mag} left by one. Each corrected
    // digit's MSB becomes the LSB of the next digit up; the ones digit takes
    // the MSB of the magnitude.
    always_comb begin
        bcd_shift = '0;
        dig       = '0;
        carry     = mag[WIDTH-1];
        for (int d = 0; d < DIGITS; d++) begin
            dig = bcd[4*d +: 4];
            if (dig >= 4'd5) begin
                dig = dig + 4'd3;
            end
            bcd_shift[4*d +: 4] = {dig[2:0], carry};
            carry               = dig[3];
        end
    end

    assign last_iter = (iter == LAST_ITER);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Busy and Done are registered copies of the next-state decode so they
    // line up exactly with the state they describe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_next;
            Busy  <= (state_next == CONV);
            Done  <= (state_next == DONE);
        end
    end

    // Digits/Neg are only written on the final iteration so they never show
    // a partial conversion.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mag     <= '0;
            bcd     <= '0;
            iter    <= '0;
            neg_reg <= 1'b0;
            Neg     <= 1'b0;
            Digits  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        mag     <= mag_abs;
                        neg_reg <= Product[WIDTH-1];
                        bcd     <= '0;
                        iter    <= '0;
                    end
                end
                CONV: begin
                    bcd  <= bcd_shift;
                    mag  <= {mag[WIDTH-2:0], 1'b0};
                    iter <= iter + CW'(1);
                    if (last_iter) begin
                        Digits <= bcd_shift;
                        Neg    <= neg_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd_converter.sv
module tb_product_bcd_converter;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [15:0] Product;
    logic        Busy;
    logic        Done;
    logic        Neg;
    logic [19:0] Digits;

    int checks   = 0;
    int failures = 0;

    logic [19:0] last_digits;
    logic        last_neg;

    product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Product (Product),
        .Busy    (Busy),
        .Done    (Done),
        .Neg     (Neg),
        .Digits  (Digits)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: sign and decimal digits from plain integer arithmetic.
    function automatic logic [20:0] model(input logic [15:0] p);
        int          v;
        int          m;
        int          pw;
        logic [19:0] d;
        v  = int'($signed(p));
        m  = (v < 0) ? -v : v;
        d  = '0;
        pw = 1;
        for (int i = 0; i < 5; i++) begin
            d[4*i +: 4] = 4'((m / pw) % 10);
            pw = pw * 10;
        end
        return {(v < 0), d};
    endfunction

    // One full conversion. mid > 0 pulses a second Start (value 5) at that
    // cycle and then scrambles Product, both of which must be ignored.
    task automatic convert(input string tag, input logic [15:0] p, input int mid);
        logic [20:0] exp;
        int          lat;
        int          extra;
        exp     = model(p);
        Product = p;
        Start   = 1'b1;
        tick();
        Start   = 1'b0;
        lat     = 0;
        check({tag, "_busy0"}, {31'd0, Busy}, 32'd1);
        while (Done !== 1'b1 && lat < 40) begin
            check({tag, "_hold"}, {10'd0, Busy, Neg, Digits}, {10'd0, 1'b1, last_neg, last_digits});
            if (mid > 0 && lat == mid) begin
                Start   = 1'b1;
                Product = 16'h0005;
            end else if (mid > 0 && lat == mid + 1) begin
                Start   = 1'b0;
                Product = 16'hAAAA;
            end
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 32'd16);
        check({tag, "_busy_at_done"}, {31'd0, Busy}, 32'd0);
        check({tag, "_result"}, {11'd0, Neg, Digits}, {11'd0, exp});
        last_neg    = exp[20];
        last_digits = exp[19:0];
        tick();
        check({tag, "_done_1cyc"}, {30'd0, Busy, Done}, 32'd0);
        if (mid > 0) begin
            extra = 0;
            for (int i = 0; i < 20; i++) begin
                if (Done === 1'b1) extra++;
                tick();
            end
            check({tag, "_no_extra_done"}, extra, 32'd0);
        end
    endtask

    initial begin
        int          seen;
        int          first_t;
        int          prev_t;
        logic [15:0] r;

        Reset       = 1'b1;
        Start       = 1'b0;
        Product     = 16'h0000;
        last_digits = '0;
        last_neg    = 1'b0;
        tick();
        tick();
        check("reset_state", {10'd0, Busy, Done, Neg, Digits}, 32'd0);

        // Reset wins over Start on the same edge.
        Start   = 1'b1;
        Product = 16'h1234;
        tick();
        check("reset_priority", {30'd0, Busy, Done}, 32'd0);
        Start = 1'b0;
        Reset = 1'b0;
        tick();

        convert("p4000", 16'h4000, 0);
        check("p4000_const", {12'd0, last_digits}, 32'h16384);
        convert("pFF80", 16'hFF80, 0);
        convert("pFFFF", 16'hFFFF, 0);
        convert("p0000", 16'h0000, 0);
        convert("p8000", 16'h8000, 0);
        check("p8000_const", {11'd0, last_neg, last_digits}, {11'd0, 1'b1, 20'h32768});
        convert("p7FFF", 16'h7FFF, 0);
        check("p7FFF_const", {11'd0, last_neg, last_digits}, {11'd0, 1'b0, 20'h32767});
        convert("p3F01", 16'h3F01, 3);

        // Abort at the 8th CONV cycle.
        Product = 16'h0100;
        Start   = 1'b1;
        tick();
        Start   = 1'b0;
        repeat (7) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort_clear", {10'd0, Busy, Done, Neg, Digits}, 32'd0);
        last_digits = '0;
        last_neg    = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (Done === 1'b1) seen++;
            tick();
        end
        check("abort_no_done", seen, 32'd0);
        convert("p0100", 16'h0100, 0);

        for (int n = 0; n < 12; n++) begin
            r = 16'($urandom);
            convert("rand", r, 0);
        end

        // Start held high: one conversion every 18 cycles.
        Product = 16'h0032;
        Start   = 1'b1;
        seen    = 0;
        first_t = -1;
        prev_t  = -1;
        for (int t = 0; t < 80 && seen < 3; t++) begin
            tick();
            if (Done === 1'b1) begin
                check("held_busy_done", {31'd0, Busy}, 32'd0);
                check("held_result", {11'd0, Neg, Digits}, {11'd0, 1'b0, 20'h00050});
                if (prev_t >= 0) check("held_period", t - prev_t, 32'd18);
                if (first_t < 0) first_t = t;
                prev_t = t;
                seen++;
            end
        end
        Start = 1'b0;
        check("held_pulses", seen, 32'd3);
        check("held_first", first_t, 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
